// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, error codes,
// FSM states, the latched request and the default legal address window.
package ysyx_23060332_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_FAULT    = 2'd2;

  localparam logic [31:0] LSU_BASE  = 32'h8000_0000;
  localparam logic [31:0] LSU_LIMIT = 32'h87ff_ffff;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} lsu_state_e;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_t;

  // Unknown funct3 encodings (including unsigned stores) share the misaligned code.
  function automatic logic misaligned(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic m;
    case (f3)
      F3_B:    m = 1'b0;
      F3_BU:   m = is_store;
      F3_H:    m = a[0];
      F3_HU:   m = is_store | a[0];
      F3_W:    m = (a != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_align.sv
// Byte-lane steering: store mask/data shift by the low address bits and
// load-result sign/zero extension. Purely combinational.
module ysyx_23060332_lsu_align
  import ysyx_23060332_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [7:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [3:0] base, lanes;

  always_comb begin
    case (funct3[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    lanes    = base << addr_lo;
    wmask    = {4'b0000, lanes};
    wdata_sh = wdata << {addr_lo, 3'b000};
  end

  // Memory already realigns read data, so extension always starts at bit 0.
  always_comb begin
    case (funct3)
      F3_B:    rdata_ext = {{24{rdata[7]}}, rdata[7:0]};
      F3_BU:   rdata_ext = {24'h0, rdata[7:0]};
      F3_H:    rdata_ext = {{16{rdata[15]}}, rdata[15:0]};
      F3_HU:   rdata_ext = {16'h0, rdata[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: EXU handshake in, SRAM-latency wait counter, memory
// strobes, access trapping, and a held result toward WBU.
module ysyx_23060332_lsu
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int          LAT   = 1,
  parameter logic [31:0] BASE  = LSU_BASE,
  parameter logic [31:0] LIMIT = LSU_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_ren,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic [1:0]  out_err
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  lsu_state_e  state, state_nx;
  lsu_req_t    req;
  logic [3:0]  cnt;
  logic        accept, last;
  logic [1:0]  acc_err;
  logic [7:0]  wmask;
  logic [31:0] wdata_sh, rdata_ext;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_RESP);
  assign accept    = in_valid && in_ready;
  assign last      = (state == S_WAIT) && (cnt == 4'd0);

  // Alignment is judged before the range check, so it wins when both apply.
  assign acc_err = misaligned(in_is_store, in_funct3, in_addr[1:0]) ? ERR_MISALIGN :
                   ((in_addr < BASE) || (in_addr > LIMIT))          ? ERR_FAULT    :
                                                                      ERR_NONE;

  ysyx_23060332_lsu_align u_align (
    .funct3    (req.funct3),
    .addr_lo   (req.addr[1:0]),
    .wdata     (req.wdata),
    .rdata     (mem_rdata),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    state_nx  = state;
    mem_ren   = 1'b0;
    mem_raddr = 32'h0;
    mem_wen   = 1'b0;
    mem_waddr = 32'h0;
    mem_wdata = 32'h0;
    mem_wmask = 8'h0;
    case (state)
      S_IDLE: if (accept) state_nx = (acc_err != ERR_NONE) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (req.is_store) begin
          mem_waddr = {req.addr[31:2], 2'b00};
          // Single write pulse on the final wait cycle only.
          if (last) begin
            mem_wen   = 1'b1;
            mem_wdata = wdata_sh;
            mem_wmask = wmask;
          end
        end else begin
          mem_ren   = 1'b1;
          mem_raddr = req.addr;
        end
        if (last) state_nx = S_RESP;
      end
      S_RESP: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req       <= '0;
      cnt       <= 4'd0;
      out_rdata <= 32'h0;
      out_rd    <= 5'd0;
      out_err   <= ERR_NONE;
    end else begin
      state <= state_nx;
      if (accept) begin
        req       <= '{is_store: in_is_store, funct3: in_funct3, addr: in_addr,
                       wdata: in_wdata, rd: in_rd};
        cnt       <= LAT_M1;
        out_rdata <= 32'h0;
        out_rd    <= 5'd0;
        out_err   <= acc_err;
      end else if (state == S_WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!req.is_store) begin
          out_rdata <= rdata_ext;
          out_rd    <= req.rd;
        end
      end
    end
  end

endmodule
